// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_C0 = 2'b00;
  localparam logic [1:0] COIN_C1 = 2'b01;
  localparam logic [1:0] COIN_C2 = 2'b10;
  localparam logic [1:0] COIN_C3 = 2'b11;

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin_code -> credit value lookup.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int COIN0_VAL = 25,
  parameter int COIN1_VAL = 50,
  parameter int COIN2_VAL = 100,
  parameter int COIN3_VAL = 10,
  parameter int CREDIT_W  = 8
) (
  input  logic [1:0]          coin_code,
  output logic [CREDIT_W-1:0] coin_val
);

  // Map each denomination code to its configured value.
  always_comb begin
    coin_val = '0;
    case (coin_code)
      COIN_C0: coin_val = CREDIT_W'(COIN0_VAL);
      COIN_C1: coin_val = CREDIT_W'(COIN1_VAL);
      COIN_C2: coin_val = CREDIT_W'(COIN2_VAL);
      COIN_C3: coin_val = CREDIT_W'(COIN3_VAL);
      default: coin_val = '0;
    endcase
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, dispenses at PRICE,
// returns change, handles cancel/refund. Optional inactivity auto-refund
// is built when VEND_TIMEOUT_EN is defined.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 100,
  parameter int COIN0_VAL   = 25,
  parameter int COIN1_VAL   = 50,
  parameter int COIN2_VAL   = 100,
  parameter int COIN3_VAL   = 10,
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 1280
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] amt_q, amt_d;
  logic                disp_q, disp_d;
  logic                cv_q, cv_d;
  logic                rej_q, rej_d;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                tmo_hit;
  logic                cancel_eff;
  logic                coin_accept;

  vend_coin_decode #(
    .COIN0_VAL (COIN0_VAL),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL),
    .COIN3_VAL (COIN3_VAL),
    .CREDIT_W  (CREDIT_W)
  ) u_dec (
    .coin_code (coin_code),
    .coin_val  (coin_val)
  );

  // Parameter rule guarantees the sum never wraps.
  assign sum         = credit_q + coin_val;
  // A timeout behaves exactly like a cancel request.
  assign cancel_eff  = cancel | tmo_hit;
  assign coin_accept = coin_valid && !cancel_eff &&
                       (state_q == ST_IDLE || state_q == ST_CREDIT);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == ST_CREDIT) && (tmo_q == TW'(TIMEOUT_CYC));

  // Count idle cycles spent in CREDIT; any coin or state exit restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_CREDIT && state_d == ST_CREDIT && !coin_accept)
      tmo_d = tmo_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  // Feature compiled out: credit is held indefinitely.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  // Next-state and registered-output decisions.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    amt_d    = amt_q;
    disp_d   = 1'b0;
    cv_d     = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // A coin arriving alongside a cancel is handed back.
        if (cancel_eff && coin_valid) rej_d = 1'b1;
        if (cancel_eff && state_q == ST_CREDIT) begin
          state_d  = ST_REFUND;
          amt_d    = credit_q;
          credit_d = '0;
          cv_d     = 1'b1;
        end else if (coin_accept) begin
          if (sum >= PRICE_C) begin
            state_d  = ST_VEND;
            amt_d    = sum - PRICE_C;
            credit_d = '0;
            disp_d   = 1'b1;
            cv_d     = (sum != PRICE_C);
          end else begin
            state_d  = ST_CREDIT;
            credit_d = sum;
          end
        end
      end
      ST_VEND, ST_REFUND: begin
        state_d = ST_IDLE;
        rej_d   = coin_valid;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, credit and output pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      amt_q    <= '0;
      disp_q   <= 1'b0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      amt_q    <= amt_d;
      disp_q   <= disp_d;
      cv_q     <= cv_d;
      rej_q    <= rej_d;
    end
  end

  assign dispense     = disp_q;
  assign change_valid = cv_q;
  assign change_amt   = amt_q;
  assign coin_reject  = rej_q;
  assign credit       = credit_q;
  assign busy         = (state_q == ST_VEND) || (state_q == ST_REFUND);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios plus
// randomized traffic against a transaction-level credit model.
module tb_vend_credit_ctrl;

  localparam int PRICE = 100;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       cancel;
  logic       dispense, change_valid, coin_reject, busy;
  logic [7:0] change_amt, credit;

  int checks = 0;
  int errors = 0;

  // Reference model state (integers, spec-level view)
  int m_credit;
  bit m_busy;
  int m_tcnt;
  bit e_disp, e_cv, e_rej;
  int e_amt;

  vend_credit_ctrl #(
    .PRICE(PRICE), .COIN0_VAL(25), .COIN1_VAL(50), .COIN2_VAL(100),
    .COIN3_VAL(10), .CREDIT_W(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code),
    .cancel(cancel), .dispense(dispense), .change_valid(change_valid),
    .change_amt(change_amt), .coin_reject(coin_reject), .credit(credit),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b00: return 25;
      2'b01: return 50;
      2'b10: return 100;
      default: return 10;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_busy = 0; m_tcnt = 0;
    e_disp = 0; e_cv = 0; e_rej = 0; e_amt = 0;
  endtask

  // One clock of the spec-level behaviour.
  task automatic model_step(input bit cv, input logic [1:0] code, input bit cc);
    bit accepted = 0;
    bit canc = cc;
    bit in_credit = !m_busy && m_credit > 0;
`ifdef VEND_TIMEOUT_EN
    if (in_credit && m_tcnt == TMO) canc = 1;
`endif
    e_disp = 0; e_cv = 0; e_rej = 0;
    if (m_busy) begin
      e_rej = cv; m_busy = 0;
    end else if (canc) begin
      e_rej = cv;
      if (m_credit > 0) begin
        e_amt = m_credit; e_cv = 1; m_credit = 0; m_busy = 1;
      end
    end else if (cv) begin
      int s = m_credit + coin_value(code);
      accepted = 1;
      if (s >= PRICE) begin
        e_disp = 1; e_amt = s - PRICE; e_cv = (s != PRICE);
        m_credit = 0; m_busy = 1;
      end else m_credit = s;
    end
    if (in_credit && !m_busy && m_credit > 0 && !accepted) m_tcnt++;
    else m_tcnt = 0;
  endtask

  task automatic cycle(input bit cv, input logic [1:0] code, input bit cc);
    coin_valid = cv; coin_code = code; cancel = cc;
    @(posedge clk);
    model_step(cv, code, cc);
    #1;
    coin_valid = 0; cancel = 0; coin_code = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    coin_valid = 0; cancel = 0; coin_code = 0;
    do_reset();
    checks++;
    if ({dispense, change_valid, coin_reject, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 0000", {dispense, change_valid, coin_reject, busy});
    end
    checks++;
    if (credit !== 8'd0 || change_amt !== 8'd0) begin
      errors++; $display("FAIL reset_values credit=%0d amt=%0d exp 0/0", credit, change_amt);
    end
  endtask

  task automatic test_exact_price();
    cycle(1, 2'b00, 0); cycle(1, 2'b00, 0);
    checks++;
    if (credit !== 8'd50) begin errors++; $display("FAIL exact_credit got %0d exp 50", credit); end
    cycle(1, 2'b01, 0);
    checks++;
    if ({dispense, change_valid, busy} !== 3'b101 || credit !== 8'd0) begin
      errors++; $display("FAIL exact_vend disp/cv/busy=%b credit=%0d exp 101/0", {dispense, change_valid, busy}, credit);
    end
    cycle(0, 2'b00, 0);
    checks++;
    if ({dispense, busy} !== 2'b00) begin errors++; $display("FAIL exact_oneshot got %b exp 00", {dispense, busy}); end
  endtask

  task automatic test_change();
    cycle(1, 2'b01, 0); cycle(1, 2'b10, 0);
    checks++;
    if ({dispense, change_valid} !== 2'b11 || change_amt !== 8'd50) begin
      errors++; $display("FAIL change disp/cv=%b amt=%0d exp 11/50", {dispense, change_valid}, change_amt);
    end
    cycle(0, 2'b00, 0);
    checks++;
    if (change_valid !== 1'b0 || change_amt !== 8'd50) begin
      errors++; $display("FAIL change_hold cv=%b amt=%0d exp 0/50", change_valid, change_amt);
    end
  endtask

  task automatic test_cancel();
    cycle(0, 2'b00, 1);
    checks++;
    if ({dispense, change_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL cancel_idle got %b exp 000", {dispense, change_valid, busy});
    end
    cycle(1, 2'b00, 0); cycle(0, 2'b00, 1);
    checks++;
    if ({dispense, change_valid, busy} !== 3'b011 || change_amt !== 8'd25 || credit !== 8'd0) begin
      errors++; $display("FAIL cancel_refund d/cv/b=%b amt=%0d credit=%0d exp 011/25/0", {dispense, change_valid, busy}, change_amt, credit);
    end
    cycle(0, 2'b00, 0);
    checks++;
    if ({change_valid, busy} !== 2'b00) begin errors++; $display("FAIL cancel_idle_after got %b exp 00", {change_valid, busy}); end
    // cancel with a coin: coin returned, refund covers prior credit only
    cycle(1, 2'b00, 0); cycle(1, 2'b01, 1);
    checks++;
    if ({change_valid, coin_reject} !== 2'b11 || change_amt !== 8'd25) begin
      errors++; $display("FAIL cancel_coin cv/rej=%b amt=%0d exp 11/25", {change_valid, coin_reject}, change_amt);
    end
    cycle(0, 2'b00, 0);
  endtask

  task automatic test_back_to_back();
    cycle(1, 2'b10, 0);
    checks++;
    if (dispense !== 1'b1) begin errors++; $display("FAIL b2b_vend got %b exp 1", dispense); end
    cycle(1, 2'b00, 0);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      errors++; $display("FAIL b2b_reject rej=%b credit=%0d exp 1/0", coin_reject, credit);
    end
    cycle(1, 2'b00, 0);
    checks++;
    if (coin_reject !== 1'b0 || credit !== 8'd25) begin
      errors++; $display("FAIL b2b_accept rej=%b credit=%0d exp 0/25", coin_reject, credit);
    end
    cycle(0, 2'b00, 1); cycle(0, 2'b00, 0);
  endtask

  task automatic test_async_reset();
    cycle(1, 2'b11, 0); cycle(1, 2'b11, 0);
    checks++;
    if (credit !== 8'd20) begin errors++; $display("FAIL areset_pre credit=%0d exp 20", credit); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (credit !== 8'd0 || {dispense, change_valid, coin_reject, busy} !== 4'b0 || change_amt !== 8'd0) begin
      errors++; $display("FAIL areset_async credit=%0d pulses=%b amt=%0d exp 0", credit, {dispense, change_valid, coin_reject, busy}, change_amt);
    end
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    cycle(1, 2'b00, 0);
    for (int i = 1; i <= TMO + 1; i++) begin
      cycle(0, 2'b00, 0);
      checks++;
      if (change_valid !== (i == TMO + 1)) begin
        errors++; $display("FAIL tmo_wait i=%0d cv=%b", i, change_valid);
      end
    end
    checks++;
    if (change_amt !== 8'd25) begin errors++; $display("FAIL tmo_amt got %0d exp 25", change_amt); end
    cycle(0, 2'b00, 0);
    cycle(1, 2'b00, 0);
    for (int i = 1; i < 10; i++) cycle(0, 2'b00, 0);
    cycle(1, 2'b11, 0);
    for (int i = 1; i <= TMO + 1; i++) begin
      cycle(0, 2'b00, 0);
      checks++;
      if (change_valid !== (i == TMO + 1)) begin
        errors++; $display("FAIL tmo_restart i=%0d cv=%b", i, change_valid);
      end
    end
    checks++;
    if (change_amt !== 8'd35) begin errors++; $display("FAIL tmo_restart_amt got %0d exp 35", change_amt); end
    cycle(0, 2'b00, 0);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit cv = ($urandom_range(0, 2) != 0);
      logic [1:0] code = 2'($urandom_range(0, 3));
      bit cc = ($urandom_range(0, 7) == 0);
      if (cc && cv && !m_busy && m_credit == 0) cc = 0;
      cycle(cv, code, cc);
      checks++;
      if (dispense !== e_disp) begin errors++; $display("FAIL rand_dispense n=%0d got %b exp %b", n, dispense, e_disp); end
      checks++;
      if (change_valid !== e_cv) begin errors++; $display("FAIL rand_cv n=%0d got %b exp %b", n, change_valid, e_cv); end
      checks++;
      if (change_amt !== 8'(e_amt)) begin errors++; $display("FAIL rand_amt n=%0d got %0d exp %0d", n, change_amt, e_amt); end
      checks++;
      if (coin_reject !== e_rej) begin errors++; $display("FAIL rand_reject n=%0d got %b exp %b", n, coin_reject, e_rej); end
      checks++;
      if (credit !== 8'(m_credit)) begin errors++; $display("FAIL rand_credit n=%0d got %0d exp %0d", n, credit, m_credit); end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL rand_busy n=%0d got %b exp %b", n, busy, m_busy); end
    end
  endtask

  initial begin
    reset = 1'b1; coin_valid = 0; cancel = 0; coin_code = 0;
    model_reset();
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_back_to_back();
    test_async_reset();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
